// File: rtl/im_port_arbiter.sv
// Arbitrates the single image-memory SRAM port between the frame copy engine (r0) and the
// clock-overlay renderer (r1). Define IM_ARB_FIXED_PRIO_EN for fixed r0 priority with preemption.
module im_port_arbiter #(
  parameter int unsigned AW        = 20,
  parameter int unsigned DW        = 24,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] rd_data,
  input  logic [DW-1:0] IM_Q,
  output logic [AW-1:0] IM_A,
  output logic [DW-1:0] IM_D,
  output logic          IM_WEN
);

`ifdef IM_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  localparam int unsigned CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] LastCnt = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_q, rr_d;  // 1: r1 wins the next contended idle grant

  logic          acc0, acc1;
  logic [AW-1:0] im_a_q;
  logic [DW-1:0] im_d_q;
  logic          im_wen_q;
  logic          tag1_vld_q, tag1_id_q, tag2_vld_q, tag2_id_q;

  assign acc0 = r0_req & r0_gnt;
  assign acc1 = r1_req & r1_gnt;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (r0_req && (!r1_req || !rr_q || FixedPrio)) state_d = StOwn0;
        else if (r1_req)                               state_d = StOwn1;
      end
      StOwn0: begin
        if (!r0_req) begin
          state_d = r1_req ? StOwn1 : StIdle;
        end else if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (r1_req && !FixedPrio) state_d = StOwn1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOwn1: begin
        if (FixedPrio && r0_req) begin
          state_d = StOwn0;
        end else if (!r1_req) begin
          state_d = r0_req ? StOwn0 : StIdle;
        end else if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (r0_req) state_d = StOwn0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Every grant change restarts the burst and points rr at the side that just lost out.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == StOwn0)      rr_d = 1'b1;
      else if (state_d == StOwn1) rr_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    r0_gnt    = (state_q == StOwn0);
    r1_gnt    = (state_q == StOwn1);
    r0_rvalid = tag2_vld_q & ~tag2_id_q;
    r1_rvalid = tag2_vld_q & tag2_id_q;
    rd_data   = IM_Q;
    IM_A      = im_a_q;
    IM_D      = im_d_q;
    IM_WEN    = im_wen_q;
  end

  // SRAM command register and read-return tag pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_a_q     <= '0;
      im_d_q     <= '0;
      im_wen_q   <= 1'b1;
      tag1_vld_q <= 1'b0;
      tag1_id_q  <= 1'b0;
      tag2_vld_q <= 1'b0;
      tag2_id_q  <= 1'b0;
    end else begin
      im_wen_q   <= 1'b1;
      tag1_vld_q <= 1'b0;
      if (acc0) begin
        im_a_q     <= r0_addr;
        im_d_q     <= r0_wdata;
        im_wen_q   <= ~r0_we;
        tag1_vld_q <= ~r0_we;
        tag1_id_q  <= 1'b0;
      end else if (acc1) begin
        im_a_q     <= r1_addr;
        im_d_q     <= r1_wdata;
        im_wen_q   <= ~r1_we;
        tag1_vld_q <= ~r1_we;
        tag1_id_q  <= 1'b1;
      end
      tag2_vld_q <= tag1_vld_q;
      tag2_id_q  <= tag1_id_q;
    end
  end

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter: cycle table plus reset, rotation, burst-wrap and
// preemption sequences against a behavioural SRAM with one-cycle read latency.
module tb_im_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [19:0] r0_addr, r1_addr;
  logic [23:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [23:0] rd_data, im_q, im_d;
  logic [19:0] im_a;
  logic        im_wen;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        r0q, r0w;
    logic [19:0] r0a;
    logic [23:0] r0d;
    logic        r1q, r1w;
    logic [19:0] r1a;
    logic [23:0] r1d;
    logic [72:0] exp;
  } vec_t;

  vec_t vecs[12];

  im_port_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rd_data(rd_data), .IM_Q(im_q), .IM_A(im_a), .IM_D(im_d), .IM_WEN(im_wen)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] sram_f(input logic [19:0] a);
    return (a == 20'hFFFFF) ? 24'h123456 : ({4'h0, a} ^ 24'h0F0F0F);
  endfunction

  always_ff @(posedge clk) im_q <= sram_f(im_a);

  function automatic logic [72:0] pk(input logic g0, input logic g1, input logic wen,
                                     input logic [19:0] a, input logic [23:0] d,
                                     input logic rv0, input logic rv1, input logic [23:0] rd);
    return {g0, g1, wen, a, d, rv0, rv1, rd};
  endfunction

  function automatic logic [72:0] obs();
    return pk(r0_gnt, r1_gnt, im_wen, im_a, im_d, r0_rvalid, r1_rvalid,
              (r0_rvalid | r1_rvalid) ? rd_data : 24'h0);
  endfunction

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0q, input logic r0w, input logic [19:0] r0a,
                       input logic [23:0] r0d, input logic r1q, input logic r1w,
                       input logic [19:0] r1a, input logic [23:0] r1d);
    r0_req = r0q; r0_we = r0w; r0_addr = r0a; r0_wdata = r0d;
    r1_req = r1q; r1_we = r1w; r1_addr = r1a; r1_wdata = r1d;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic sv(input int k, input logic r0q, input logic r0w, input logic [19:0] r0a,
                    input logic [23:0] r0d, input logic r1q, input logic r1w,
                    input logic [19:0] r1a, input logic [23:0] r1d, input logic [72:0] e);
    vecs[k] = '{r0q, r0w, r0a, r0d, r1q, r1w, r1a, r1d, e};
  endtask

  initial begin
    // Each row: inputs held for one cycle, then the outputs expected just after that edge.
    sv(0,  1, 1, 20'h00010, 24'hA1B2C3, 0, 0, 20'h0,     24'h0,
        pk(1, 0, 1, 20'h0,     24'h0,     0, 0, 24'h0));
    sv(1,  1, 1, 20'h00010, 24'hA1B2C3, 0, 0, 20'h0,     24'h0,
        pk(1, 0, 0, 20'h00010, 24'hA1B2C3, 0, 0, 24'h0));
    sv(2,  0, 0, 20'h0,     24'h0,     1, 0, 20'hFFFFF, 24'h777777,
        pk(0, 1, 1, 20'h00010, 24'hA1B2C3, 0, 0, 24'h0));
    sv(3,  0, 0, 20'h0,     24'h0,     1, 0, 20'hFFFFF, 24'h777777,
        pk(0, 1, 1, 20'hFFFFF, 24'h777777, 0, 0, 24'h0));
    sv(4,  0, 0, 20'h0,     24'h0,     0, 0, 20'h0,     24'h0,
        pk(0, 0, 1, 20'hFFFFF, 24'h777777, 0, 1, 24'h123456));
    sv(5,  0, 0, 20'h0,     24'h0,     0, 0, 20'h0,     24'h0,
        pk(0, 0, 1, 20'hFFFFF, 24'h777777, 0, 0, 24'h0));
    sv(6,  1, 0, 20'h00100, 24'h000001, 1, 0, 20'h00200, 24'h000002,
        pk(1, 0, 1, 20'hFFFFF, 24'h777777, 0, 0, 24'h0));
    sv(7,  1, 0, 20'h00100, 24'h000001, 1, 0, 20'h00200, 24'h000002,
        pk(1, 0, 1, 20'h00100, 24'h000001, 0, 0, 24'h0));
    sv(8,  0, 0, 20'h0,     24'h0,     1, 0, 20'h00200, 24'h000002,
        pk(0, 1, 1, 20'h00100, 24'h000001, 1, 0, 24'h0F0E0F));
    sv(9,  0, 0, 20'h0,     24'h0,     1, 0, 20'h00200, 24'h000002,
        pk(0, 1, 1, 20'h00200, 24'h000002, 0, 0, 24'h0));
    sv(10, 0, 0, 20'h0,     24'h0,     0, 0, 20'h0,     24'h0,
        pk(0, 0, 1, 20'h00200, 24'h000002, 0, 1, 24'h0F0D0F));
    sv(11, 0, 0, 20'h0,     24'h0,     0, 0, 20'h0,     24'h0,
        pk(0, 0, 1, 20'h00200, 24'h000002, 0, 0, 24'h0));

    do_reset();
    check("reset_state", obs(), pk(0, 0, 1, 0, 0, 0, 0, 0));

    for (int k = 0; k < 12; k++) begin
      drive(vecs[k].r0q, vecs[k].r0w, vecs[k].r0a, vecs[k].r0d,
            vecs[k].r1q, vecs[k].r1w, vecs[k].r1a, vecs[k].r1d);
      step();
      check($sformatf("vec%0d", k), obs(), vecs[k].exp);
    end

    // Reset asserted between edges must clear outputs without waiting for a clock.
    #2 reset = 1'b0;
    #1 check("async_reset", obs(), pk(0, 0, 1, 0, 0, 0, 0, 0));
    step();
    reset = 1'b1;

`ifndef IM_ARB_FIXED_PRIO_EN
    // Both sides write continuously: 16-accept bursts alternating, one write every cycle.
    do_reset();
    drive(1, 1, 20'h00AAA, 24'hAAAAAA, 1, 1, 20'h00BBB, 24'hBBBBBB);
    for (int i = 0; i < 41; i++) begin
      logic        eg0;
      logic [19:0] ea;
      logic [23:0] ed;
      step();
      eg0 = ((i / 16) % 2) == 0;
      if (i == 0) begin
        ea = 20'h0;
        ed = 24'h0;
      end else if (((i - 1) / 16) % 2 == 0) begin
        ea = 20'h00AAA;
        ed = 24'hAAAAAA;
      end else begin
        ea = 20'h00BBB;
        ed = 24'hBBBBBB;
      end
      check($sformatf("rotate%0d", i), obs(), pk(eg0, ~eg0, (i == 0), ea, ed, 0, 0, 0));
    end
`endif

    // Lone owner past MAX_BURST keeps the grant.
    do_reset();
    drive(1, 1, 20'h00042, 24'h424242, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("wrap%0d", i), {71'h0, r0_gnt, r1_gnt}, {71'h0, 2'b10});
    end

    // Reset in the middle of a read burst flushes pending returns and rr state.
    do_reset();
    drive(1, 0, 20'h00300, 24'h0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step();
    r1_req = 1'b1;
    reset = 1'b0;
    #1 check("burst_reset", obs(), pk(0, 0, 1, 0, 0, 0, 0, 0));
    step();
    check("burst_reset_hold0", obs(), pk(0, 0, 1, 0, 0, 0, 0, 0));
    step();
    check("burst_reset_hold1", obs(), pk(0, 0, 1, 0, 0, 0, 0, 0));
    reset = 1'b1;
    step();
    check("post_reset_gnt", obs(), pk(1, 0, 1, 0, 0, 0, 0, 0));
    step();
    check("post_reset_acc", obs(), pk(1, 0, 1, 20'h00300, 24'h0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

`ifdef IM_ARB_FIXED_PRIO_EN
    // r0 preempts a running r1 burst; r1's last accepted read still returns.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 20'h00400, 24'h0);
    step();
    step();
    step();
    drive(1, 1, 20'h00500, 24'h555555, 1, 0, 20'h00400, 24'h0);
    step();
    check("preempt", obs(), pk(1, 0, 1, 20'h00400, 24'h0, 0, 1, 24'h0F0B0F));
    r1_req = 1'b0;
    step();
    check("preempt_ret", obs(), pk(1, 0, 0, 20'h00500, 24'h555555, 0, 1, 24'h0F0B0F));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
